// File: rtl/sp_mul_arb_pkg.sv
// Shared types and IEEE-754 single-precision field helpers for sp_mul_arbiter.
package sp_mul_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam int         SIGN_BIT = 31;
  localparam int         EXP_MSB  = 30;
  localparam int         EXP_LSB  = 23;
  localparam logic [7:0] EXP_MAX  = 8'hFF;

  // +0 or -0: everything except the sign is clear
  function automatic logic is_zero(input logic [31:0] x);
    return x[EXP_MSB:0] == '0;
  endfunction

  function automatic logic is_inf_nan(input logic [31:0] x);
    return x[EXP_MSB:EXP_LSB] == EXP_MAX;
  endfunction

  function automatic logic [31:0] signed_zero(input logic [31:0] a, input logic [31:0] b);
    return {a[SIGN_BIT] ^ b[SIGN_BIT], 31'b0};
  endfunction

endpackage

// File: rtl/sp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past last_grant and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    int cand;
    cand      = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_any && req[cand[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = grant_any && (grant_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/sp_mul_arbiter.sv
// Shares one stb/ack single-precision multiplier among NUM_REQ requesters.
// Optional zero-operand shortcut enabled by defining SP_MUL_ARB_ZERO_BYPASS_EN.
module sp_mul_arbiter
  import sp_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_z,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            mul_a,
  output logic                   mul_a_stb,
  input  logic                   mul_a_ack,
  output logic [31:0]            mul_b,
  output logic                   mul_b_stb,
  input  logic                   mul_b_ack,
  input  logic [31:0]            mul_z,
  input  logic                   mul_z_stb,
  output logic                   mul_z_ack,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   last_grant_reg, last_grant_next;
  logic [31:0]        a_reg, a_next;
  logic [31:0]        b_reg, b_next;
  logic [31:0]        rsp_z_reg, rsp_z_next;
  logic [CNT_W-1:0]   op_count_reg, op_count_next;
  logic               a_stb_reg, a_stb_next;
  logic               b_stb_reg, b_stb_next;
  logic               z_ack_reg, z_ack_next;
  logic               rsp_valid_reg, rsp_valid_next;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] req_ready_int;
  logic [31:0]        sel_a, sel_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a = req_a[i*32 +: 32];
        sel_b = req_b[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      a_reg          <= '0;
      b_reg          <= '0;
      rsp_z_reg      <= '0;
      op_count_reg   <= '0;
      a_stb_reg      <= 1'b0;
      b_stb_reg      <= 1'b0;
      z_ack_reg      <= 1'b0;
      rsp_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      rsp_z_reg      <= rsp_z_next;
      op_count_reg   <= op_count_next;
      a_stb_reg      <= a_stb_next;
      b_stb_reg      <= b_stb_next;
      z_ack_reg      <= z_ack_next;
      rsp_valid_reg  <= rsp_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    rsp_z_next      = rsp_z_reg;
    op_count_next   = op_count_reg;
    a_stb_next      = a_stb_reg;
    b_stb_next      = b_stb_reg;
    z_ack_next      = z_ack_reg;
    rsp_valid_next  = rsp_valid_reg;
    req_ready_int   = '0;

    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          req_ready_int = grant;
          a_next        = sel_a;
          b_next        = sel_b;
          owner_next    = grant_idx;
`ifdef SP_MUL_ARB_ZERO_BYPASS_EN
          // A finite-or-zero times zero is a signed zero; Inf/NaN still need the multiplier
          if ((is_zero(sel_a) && !is_inf_nan(sel_b)) ||
              (is_zero(sel_b) && !is_inf_nan(sel_a))) begin
            rsp_z_next     = signed_zero(sel_a, sel_b);
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end else begin
            a_stb_next = 1'b1;
            state_next = SEND_A;
          end
`else
          a_stb_next = 1'b1;
          state_next = SEND_A;
`endif
        end
      end
      SEND_A: begin
        if (a_stb_reg && mul_a_ack) begin
          a_stb_next = 1'b0;
          b_stb_next = 1'b1;
          state_next = SEND_B;
        end
      end
      SEND_B: begin
        if (b_stb_reg && mul_b_ack) begin
          b_stb_next = 1'b0;
          z_ack_next = 1'b1;
          state_next = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (z_ack_reg && mul_z_stb) begin
          rsp_z_next     = mul_z;
          z_ack_next     = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[owner_reg]) begin
          rsp_valid_next  = 1'b0;
          last_grant_next = owner_reg;
          op_count_next   = op_count_reg + CNT_W'(1);
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The accept pulse is combinational, so mask it while reset is asserted
  assign req_ready = rst ? req_ready_int : '0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = rsp_valid_reg && (owner_reg == IDX_W'(gi));
  end

  assign rsp_z     = rsp_z_reg;
  assign mul_a     = a_reg;
  assign mul_a_stb = a_stb_reg;
  assign mul_b     = b_reg;
  assign mul_b_stb = b_stb_reg;
  assign mul_z_ack = z_ack_reg;
  assign busy      = (state_reg != IDLE);
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_sp_mul_arbiter.sv
// Directed bench for sp_mul_arbiter; the bench plays both the requesters and the multiplier.
module tb_sp_mul_arbiter;

  localparam int NUM = 4;
  localparam int CW  = 16;

  logic              clk;
  logic              rst;
  logic [NUM-1:0]    req_valid;
  logic [32*NUM-1:0] req_a;
  logic [32*NUM-1:0] req_b;
  logic [NUM-1:0]    req_ready;
  logic [NUM-1:0]    rsp_valid;
  logic [31:0]       rsp_z;
  logic [NUM-1:0]    rsp_ready;
  logic [31:0]       mul_a;
  logic              mul_a_stb;
  logic              mul_a_ack;
  logic [31:0]       mul_b;
  logic              mul_b_stb;
  logic              mul_b_ack;
  logic [31:0]       mul_z;
  logic              mul_z_stb;
  logic              mul_z_ack;
  logic              busy;
  logic [CW-1:0]     op_count;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  sp_mul_arbiter #(.NUM_REQ(NUM), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_z     (rsp_z),
    .rsp_ready (rsp_ready),
    .mul_a     (mul_a),
    .mul_a_stb (mul_a_stb),
    .mul_a_ack (mul_a_ack),
    .mul_b     (mul_b),
    .mul_b_stb (mul_b_stb),
    .mul_b_ack (mul_b_ack),
    .mul_z     (mul_z),
    .mul_z_stb (mul_z_stb),
    .mul_z_ack (mul_z_ack),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input logic [NUM-1:0] exp_oh);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      if (req_ready != '0) got = 1'b1;
      else @(negedge clk);
    end
    total++;
    assert (got) else begin
      bad++;
      $error("FAIL grant_timeout: observed=none expected=%b", exp_oh);
    end
    check("req_ready", 32'(req_ready), 32'(exp_oh));
    $display("grant req_ready=%b expected=%b", req_ready, exp_oh);
  endtask

  // One complete operation from requester idx; byp means the zero shortcut is expected
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] z, input int stall_a, input int rsp_wait,
                        input bit keep, input bit byp);
    logic [NUM-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_valid[idx] = 1'b1;
    wait_grant(oh);
    @(negedge clk);
    if (!keep) req_valid[idx] = 1'b0;
    if (byp) begin
      check("byp_a_stb", 32'(mul_a_stb), 32'd0);
      check("byp_rsp_valid", 32'(rsp_valid), 32'(oh));
      check("byp_rsp_z", rsp_z, z);
    end else begin
      check("a_stb", 32'(mul_a_stb), 32'd1);
      check("mul_a", mul_a, a);
      check("busy", 32'(busy), 32'd1);
      for (int s = 0; s < stall_a; s++) begin
        @(negedge clk);
        check("a_stb_hold", 32'(mul_a_stb), 32'd1);
        check("mul_a_hold", mul_a, a);
      end
      mul_a_ack = 1'b1;
      @(negedge clk);
      mul_a_ack = 1'b0;
      check("a_stb_clr", 32'(mul_a_stb), 32'd0);
      check("b_stb", 32'(mul_b_stb), 32'd1);
      check("mul_b", mul_b, b);
      mul_b_ack = 1'b1;
      @(negedge clk);
      mul_b_ack = 1'b0;
      check("b_stb_clr", 32'(mul_b_stb), 32'd0);
      check("z_ack", 32'(mul_z_ack), 32'd1);
      mul_z = z;
      mul_z_stb = 1'b1;
      @(negedge clk);
      mul_z_stb = 1'b0;
      check("z_ack_clr", 32'(mul_z_ack), 32'd0);
      check("rsp_valid", 32'(rsp_valid), 32'(oh));
      check("rsp_z", rsp_z, z);
    end
    for (int s = 0; s < rsp_wait; s++) begin
      rsp_ready = ~oh;
      @(negedge clk);
      check("rsp_valid_hold", 32'(rsp_valid), 32'(oh));
      check("rsp_z_hold", rsp_z, z);
      check("a_stb_idle", 32'(mul_a_stb), 32'd0);
    end
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = '0;
    exp_count++;
    check("rsp_valid_clr", 32'(rsp_valid), 32'd0);
    check("op_count", 32'(op_count), 32'(exp_count));
    $display("op req=%0d a=%h b=%h rsp_z=%h expected=%h op_count=%0d", idx, a, b, rsp_z, z, op_count);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '0;
    mul_a_ack = 1'b0;
    mul_b_ack = 1'b0;
    mul_z = '0;
    mul_z_stb = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_a_stb", 32'(mul_a_stb), 32'd0);
    check("rst_b_stb", 32'(mul_b_stb), 32'd0);
    check("rst_z_ack", 32'(mul_z_ack), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_z", rsp_z, 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);

    // Round robin: all four hold valid from reset release
    for (int i = 0; i < NUM; i++) begin
      req_a[i*32 +: 32] = 32'h3F80_0000 + 32'(i);
      req_b[i*32 +: 32] = 32'h4000_0000 + 32'(i);
    end
    req_valid = '1;
    rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      run_op(n % NUM, 32'h3F80_0000 + 32'(n % NUM), 32'h4000_0000 + 32'(n % NUM),
             32'hA000_0000 + 32'(n), 0, 0, 1'b1, 1'b0);
    end
    req_valid = '0;

    // 2.0 * 3.0 from requester 0
    run_op(0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 0, 1'b0, 1'b0);
    check("busy_after", 32'(busy), 32'd0);

    // Stall operand A for 10 cycles, hold the response for 5 with foreign rsp_ready
    run_op(2, 32'h3F80_0000, 32'hC000_0000, 32'hC000_0000, 10, 5, 1'b0, 1'b0);

`ifdef SP_MUL_ARB_ZERO_BYPASS_EN
    run_op(1, 32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 0, 2, 1'b0, 1'b1);
    run_op(3, 32'h0000_0000, 32'h7F80_0000, 32'hFFC0_0000, 0, 0, 1'b0, 1'b0);
`else
    run_op(1, 32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 0, 0, 1'b0, 1'b0);
`endif

    // Reset while waiting for the result
    req_valid = 4'b0010;
    wait_grant(4'b0010);
    @(negedge clk);
    req_valid = '0;
    mul_a_ack = 1'b1;
    @(negedge clk);
    mul_a_ack = 1'b0;
    mul_b_ack = 1'b1;
    @(negedge clk);
    mul_b_ack = 1'b0;
    check("pre_rst_z_ack", 32'(mul_z_ack), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_z_ack", 32'(mul_z_ack), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_op_count", 32'(op_count), 32'd0);
    req_valid = '1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_grant(4'b0001);
    check("post_rst_op_count", 32'(op_count), 32'd0);
    $display("reset mid-op op_count=%0d", op_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_mul_arbiter.md
Name: sp_mul_arbiter

Overview:
Shares one single-precision multiplier (stb/ack operand and result handshake) between NUM_REQ requesters. Round-robin arbitration; the block sequences operand A, operand B, then result collection. The result goes back to the owning requester only. Sits between client engines and the multiplier instance. The multiplier's own reset is driven by the top level.

Parameters:
NUM_REQ, 4, number of requesters (1..16)
CNT_W, 16, width of the completed-operation counter
IDX_W, $clog2(NUM_REQ) with a minimum of 1, localparam, owner index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
req_valid  in  NUM_REQ  per-requester operation request
req_a  in  32*NUM_REQ  operand A, slice i belongs to requester i
req_b  in  32*NUM_REQ  operand B, slice i belongs to requester i
req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
rsp_valid  out  NUM_REQ  result valid, one-hot to owner
rsp_z  out  32  result value, shared bus
rsp_ready  in  NUM_REQ  requester accepts result
mul_a  out  32  operand A to multiplier
mul_a_stb  out  1  operand A strobe
mul_a_ack  in  1  operand A acknowledge
mul_b  out  32  operand B to multiplier
mul_b_stb  out  1  operand B strobe
mul_b_ack  in  1  operand B acknowledge
mul_z  in  32  multiplier result
mul_z_stb  in  1  result strobe
mul_z_ack  out  1  result acknowledge
busy  out  1  1 in any state other than IDLE
op_count  out  CNT_W  completed operations, wraps to 0

Behaviour:
- Reset values: state IDLE; all stb/ack/valid outputs 0; mul_a, mul_b, rsp_z 0; op_count 0; last_grant = NUM_REQ-1, so requester 0 wins first.
- Transfer rule on every handshake: a transfer occurs when stb and ack are both 1 in the same cycle. Strobes and acks are registered.
- IDLE: round-robin search, starting at last_grant+1 and wrapping.
  - If any req_valid is set: req_ready[winner]=1 combinationally in this cycle; latch req_a/req_b slices and the owner index; go to SEND_A.
  - Requester holds valid and operands until ready. Dropping valid early is a protocol violation and is not checked.
- SEND_A: mul_a_stb=1, mul_a=latched A. On transfer, clear the stb and go to SEND_B.
- SEND_B: the same sequence using mul_b/mul_b_stb. On transfer, go to WAIT_Z.
- WAIT_Z: mul_z_ack=1. On transfer, capture mul_z into rsp_z, clear the ack, go to RESP.
- RESP: rsp_valid[owner]=1 and rsp_z stays stable. On rsp_ready[owner]: clear valid, last_grant=owner, op_count+1, go to IDLE.
- Minimum latency from req_ready to rsp_valid is 3 cycles plus multiplier time. There is no idle cycle after RESP beyond the IDLE arbitration cycle.
- Requests arriving while busy wait; they are not queued. rsp_ready on non-owners is ignored.
- Reset mid-operation: the transaction is abandoned, all outputs return to reset values immediately, and no response is issued. The top level must reset the multiplier at the same time.
- With NUM_REQ=1, the block degenerates to a sequencer.

Optional Feature:
Macro SP_MUL_ARB_ZERO_BYPASS_EN.
- Defined: in IDLE, the latched operands are checked.
  - Bypass applies if one operand is ±0 (bits[30:0]==0) and the other has exponent != 8'hFF.
  - Bypass then skips SEND_A/SEND_B/WAIT_Z and goes straight to RESP with rsp_z = {a[31]^b[31], 31'b0}. The multiplier is untouched.
  - Zero × Inf and zero × NaN still use the multiplier.
- Undefined: every operation uses the multiplier and the bypass logic is absent.

Decomposition:
- Package sp_mul_arb_pkg holds:
  - state enum (IDLE, SEND_A, SEND_B, WAIT_Z, RESP)
  - float field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, EXP_MAX=8'hFF
  - is_zero / is_inf_nan helper functions
- One sub-module, rr_arbiter: inputs request vector and last_grant; outputs one-hot grant and index. Purely combinational.

Test Plan:
- Requester 0, a=0x40000000 (2.0), b=0x40400000 (3.0) -> rsp_valid[0], rsp_z=0x40C00000, op_count=1, busy returns 0.
- All 4 req_valid held from reset release, 8 operations -> grant order 0,1,2,3,0,1,2,3; each rsp_valid only on its owner.
- Stall mul_a_ack for 10 cycles, then rsp_ready[owner] for 5 cycles -> mul_a_stb and mul_a held stable throughout; rsp_valid and rsp_z held until ready; exactly one transfer each.
- Drive rst=0 during WAIT_Z -> mul_z_ack, busy and rsp_valid go 0 without a clock edge; after release, requester 0 is granted first and op_count=0.
- With macro: a=0x80000000, b=0x40400000 -> rsp_z=0x80000000 and mul_a_stb never rises. a=0x00000000, b=0x7F800000 -> goes through the multiplier and returns 0xFFC00000.
- Without macro: a=0x80000000, b=0x40400000 -> the multiplier handshake occurs and rsp_z=0x80000000.
